// File: rtl/jts16b_divider_pkg.sv
// Shared constants, register map and FSM states for the jts16b 32-bit signed divider.
package jts16b_divider_pkg;

  localparam int DIV_W = 32;

  localparam logic [2:0] REG_DVD_HI = 3'd0;
  localparam logic [2:0] REG_DVD_LO = 3'd1;
  localparam logic [2:0] REG_DIV_HI = 3'd2;
  localparam logic [2:0] REG_DIV_LO = 3'd3;
  localparam logic [2:0] REG_QUO_HI = 3'd4;
  localparam logic [2:0] REG_QUO_LO = 3'd5;
  localparam logic [2:0] REG_REM_HI = 3'd6;
  localparam logic [2:0] REG_REM_LO = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX
  } div_state_t;

  // Byte-lane merge for 68000 writes; dsn is active low {UDSn, LDSn}.
  function automatic logic [15:0] lane_merge(input logic [15:0] old_val,
                                             input logic [15:0] new_val,
                                             input logic [1:0]  dsn);
    lane_merge = {dsn[1] ? old_val[15:8] : new_val[15:8],
                  dsn[0] ? old_val[7:0]  : new_val[7:0]};
  endfunction

endpackage

// File: rtl/jts16b_div_core.sv
// Unsigned restoring divider core: resolves BPC quotient bits per enabled cycle.
module jts16b_div_core
  import jts16b_divider_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cen,
  input  logic             start,
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  output logic [DIV_W-1:0] q,
  output logic [DIV_W-1:0] r,
  output logic             done
);

  localparam int N     = DIV_W / BPC;
  localparam int CNT_W = 6;

  logic [DIV_W-1:0] q_q, q_d, r_q, r_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]   trial;

  // The quotient register doubles as the dividend shifter; the remainder fills from its MSB.
  always_comb begin
    q_d   = q_q;
    r_d   = r_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    trial = '0;
    if (cen) begin
      if (start) begin
        q_d   = a;
        r_d   = '0;
        b_d   = b;
        cnt_d = CNT_W'(N);
      end else if (cnt_q != '0) begin
        for (int i = 0; i < BPC; i++) begin
          trial = {r_d, q_d[DIV_W-1]};
          q_d   = {q_d[DIV_W-2:0], 1'b0};
          if (trial >= {1'b0, b_q}) begin
            trial  = trial - {1'b0, b_q};
            q_d[0] = 1'b1;
          end
          r_d = trial[DIV_W-1:0];
        end
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q   <= '0;
      r_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      r_q   <= r_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/jts16b_divider.sv
// S16B 315-5249-style signed divider: bus registers, sign handling, saturation and sequencing FSM.
module jts16b_divider
  import jts16b_divider_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cen,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic [15:0] din,
  input  logic [1:0]  dsn,
  input  logic        rnw,
  output logic [15:0] dout,
  output logic        busy,
  output logic        ovf
);

  div_state_t state_q, state_d;
  logic [DIV_W-1:0] dividend_q, dividend_d, divisor_q, divisor_d;
  logic [DIV_W-1:0] quot_q, quot_d, rem_q, rem_d, snap_dvd_q, snap_dvd_d;
  logic mode_q, mode_d, ovf_q, ovf_d;
  logic num_neg_q, num_neg_d, den_neg_q, den_neg_d, zero_q, zero_d;
  logic [15:0] dout_q, dout_d;

  logic wr, start, core_start, core_done, q_neg, fix_ovf;
  logic [DIV_W-1:0] div_eff, core_a, core_b, core_q, core_r, fix_q, fix_r;

  // Mode 0 is a 32/16 divide: only the sign-extended low divisor half takes part.
  always_comb begin
    div_eff = mode_q ? divisor_q : {{16{divisor_q[15]}}, divisor_q[15:0]};
    core_a  = dividend_q[DIV_W-1] ? -dividend_q : dividend_q;
    core_b  = div_eff[DIV_W-1] ? -div_eff : div_eff;
  end

  jts16b_div_core #(.BPC(BPC)) u_core (
    .clk   (clk),
    .rstn  (rstn),
    .cen   (cen),
    .start (core_start),
    .a     (core_a),
    .b     (core_b),
    .q     (core_q),
    .r     (core_r),
    .done  (core_done)
  );

  // A positive magnitude of 2^31 in mode 1 only arises from 0x80000000 / -1.
  always_comb begin
    q_neg   = num_neg_q ^ den_neg_q;
    fix_q   = q_neg ? -core_q : core_q;
    fix_r   = num_neg_q ? -core_r : core_r;
    fix_ovf = 1'b0;
    if (zero_q) begin
      fix_q   = snap_dvd_q[DIV_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      fix_r   = snap_dvd_q;
      fix_ovf = 1'b1;
    end else if (mode_q) begin
      if (!q_neg && core_q[DIV_W-1]) begin
        fix_q   = 32'h7FFF_FFFF;
        fix_ovf = 1'b1;
      end
    end else if (q_neg ? (core_q > 32'd32768) : (core_q > 32'd32767)) begin
      fix_q   = q_neg ? 32'hFFFF_8000 : 32'h0000_7FFF;
      fix_ovf = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    snap_dvd_d = snap_dvd_q;
    mode_d     = mode_q;
    ovf_d      = ovf_q;
    num_neg_d  = num_neg_q;
    den_neg_d  = den_neg_q;
    zero_d     = zero_q;
    core_start = 1'b0;
    wr         = cs & ~rnw & cen;
    start      = wr && (addr[2:0] == REG_DIV_LO) && (dsn != 2'b11);

    if (wr) begin
      case (addr[2:0])
        REG_DVD_HI: dividend_d[31:16] = lane_merge(dividend_q[31:16], din, dsn);
        REG_DVD_LO: dividend_d[15:0]  = lane_merge(dividend_q[15:0], din, dsn);
        REG_DIV_HI: divisor_d[31:16]  = lane_merge(divisor_q[31:16], din, dsn);
        REG_DIV_LO: divisor_d[15:0]   = lane_merge(divisor_q[15:0], din, dsn);
        default: ;
      endcase
    end

    case (state_q)
      ST_PREP: if (cen) begin
        core_start = 1'b1;
        num_neg_d  = dividend_q[DIV_W-1];
        den_neg_d  = div_eff[DIV_W-1];
        zero_d     = (div_eff == '0);
        snap_dvd_d = dividend_q;
        state_d    = (div_eff == '0) ? ST_FIX : ST_ITER;
      end
      ST_ITER: if (cen && core_done) state_d = ST_FIX;
      ST_FIX: if (cen) begin
        quot_d  = fix_q;
        rem_d   = fix_r;
        ovf_d   = fix_ovf;
        state_d = ST_IDLE;
      end
      default: ;
    endcase

    // A restart wins over everything, including a result about to be published.
    if (start) begin
      state_d = ST_PREP;
      mode_d  = addr[3];
      quot_d  = quot_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
    end

    case (addr[2:0])
      REG_DVD_HI: dout_d = dividend_q[31:16];
      REG_DVD_LO: dout_d = dividend_q[15:0];
      REG_DIV_HI: dout_d = divisor_q[31:16];
      REG_DIV_LO: dout_d = divisor_q[15:0];
      REG_QUO_HI: dout_d = quot_q[31:16];
      REG_QUO_LO: dout_d = quot_q[15:0];
      REG_REM_HI: dout_d = rem_q[31:16];
      default:    dout_d = rem_q[15:0];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      snap_dvd_q <= '0;
      mode_q     <= 1'b0;
      ovf_q      <= 1'b0;
      num_neg_q  <= 1'b0;
      den_neg_q  <= 1'b0;
      zero_q     <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      snap_dvd_q <= snap_dvd_d;
      mode_q     <= mode_d;
      ovf_q      <= ovf_d;
      num_neg_q  <= num_neg_d;
      den_neg_q  <= den_neg_d;
      zero_q     <= zero_d;
      dout_q     <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q != ST_IDLE);
  assign ovf  = ovf_q;

endmodule
